// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch
// ----------------------------------------------------------------------------
// Instruction fetch unit. It fetches from instruction memory using a
// request/grant/rvalid handshake and keeps at most one access in flight. The
// returned words go into a 2-entry buffer, and decode drains that buffer.
// The unit tells the PC to advance when an address is accepted. A branch
// (flush) empties the buffer and drops any response still in flight.
//
// Parameters
//   DATA_WIDTH  instruction / address width (default 32)
//   BUF_DEPTH   instruction buffer entries (only 2 is supported)
//
// Ports
//   clk_i               clock, rising edge
//   reset_i             asynchronous, active-low reset
//   pc_addr_i           current PC value
//   pc_en_o             one-cycle pulse: advance PC by 4
//   flush_i             branch taken (same signal as the PC's branch enable)
//   mem_req_o           instruction memory request
//   mem_addr_o          request address
//   mem_gnt_i           memory accepted the address
//   mem_rvalid_i        memory read data valid
//   mem_rdata_i         memory read data
//   instr_valid_o       buffer head valid
//   instr_o             head instruction
//   instr_addr_o        head instruction address
//   instr_ready_i       decode accepts the head
//   fetch_misaligned_o  misaligned-PC flag
//
// Optional feature (compile-time macro IFETCH_ALIGN_CHECK_EN)
//   Defined     : in IDLE, a PC with address bits [1:0] != 0 blocks issue and
//                 sets fetch_misaligned_o. The flag stays set until flush_i.
//   Not defined : PC low bits pass through unchecked and
//                 fetch_misaligned_o is tied to 0.
// ============================================================================
module instr_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] pc_addr_i,
    output logic                  pc_en_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_ready_i,
    output logic                  fetch_misaligned_o
);

    // A new fetch may start only while the buffer has room for its response.
    // The access is only accepted when count <= BUF_DEPTH-1, so a push can
    // never find the buffer full.
    localparam logic [1:0] ISSUE_MAX = 2'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  align_ok;

    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_addr [BUF_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic                  misaligned;

    // Sticky misalignment flag. It is set when IDLE sees a misaligned PC and
    // is cleared only by a branch, which supplies a fresh PC.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            misaligned <= 1'b0;
        end else if (flush_i) begin
            misaligned <= 1'b0;
        end else if ((state == IDLE) && (pc_addr_i[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end

    assign align_ok           = (pc_addr_i[1:0] == 2'b00) && !misaligned;
    assign fetch_misaligned_o = misaligned;
`else
    assign align_ok           = 1'b1;
    assign fetch_misaligned_o = 1'b0;
`endif

    // Next-state and handshake decode. A flush always suppresses the PC
    // advance and any buffer push. A flush that arrives after the grant must
    // still consume the response, so it goes through DISCARD.
    always_comb begin
        state_next = state;
        pc_en_o    = 1'b0;
        push       = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (!flush_i && (count <= ISSUE_MAX) && align_ok) begin
                    issue      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_next = mem_gnt_i ? DISCARD : IDLE;
                end else if (mem_gnt_i) begin
                    pc_en_o    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_next = mem_rvalid_i ? IDLE : DISCARD;
                end else if (mem_rvalid_i) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            DISCARD: begin
                if (mem_rvalid_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request address is captured when the fetch starts. It then holds
    // steady for the whole request and also tags the response.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mem_addr_o <= '0;
        end else if (issue) begin
            mem_addr_o <= pc_addr_i;
        end
    end

    assign mem_req_o = (state == REQ);

    assign pop = instr_valid_o && instr_ready_i;

    // Two-entry circular buffer with one-bit pointers. A flush takes priority
    // and empties it. A push and a pop in the same cycle keep the count.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_addr[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= mem_rdata_i;
                buf_addr[wr_ptr] <= mem_addr_o;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The head is driven to zero while the buffer is empty, so stale entries
    // never show up on the outputs.
    assign instr_valid_o = (count != 2'd0);
    assign instr_o       = instr_valid_o ? buf_data[rd_ptr] : '0;
    assign instr_addr_o  = instr_valid_o ? buf_addr[rd_ptr] : '0;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction and address width.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; only the value 2 is supported.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 reset_i  input  1  reset, asynchronous, active-low.
REQ-005 pc_addr_i  input  32  current PC value (instr_addr_o of pc).
REQ-006 pc_en_o  output  1  one-cycle pulse; advances PC by 4.
REQ-007 flush_i  input  1  branch taken; same signal as pc branch_en_i.
REQ-008 mem_req_o  output  1  instruction memory request.
REQ-009 mem_addr_o  output  32  request address.
REQ-010 mem_gnt_i  input  1  address accepted.
REQ-011 mem_rvalid_i  input  1  read data valid.
REQ-012 mem_rdata_i  input  32  read data.
REQ-013 instr_valid_o  output  1  buffer head valid.
REQ-014 instr_o  output  32  head instruction.
REQ-015 instr_addr_o  output  32  head instruction address.
REQ-016 instr_ready_i  input  1  decode accepts head.
REQ-017 fetch_misaligned_o  output  1  misaligned-PC flag (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and DISCARD; at most one memory transaction is outstanding.
REQ-019 IDLE->REQ SHALL occur when flush_i=0 and buffer count <= 1; on that edge mem_addr_o SHALL register pc_addr_i.
REQ-020 mem_req_o SHALL be 1 exactly while in REQ; mem_addr_o SHALL stay stable throughout REQ.
REQ-021 In REQ, mem_gnt_i=1 SHALL transition to WAIT and assert pc_en_o combinationally in that cycle.
REQ-022 In WAIT, mem_rvalid_i=1 SHALL push {mem_addr_o, mem_rdata_i} into the buffer and transition to IDLE.
REQ-023 Zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle) SHALL give instr_valid_o=1 three cycles after the IDLE cycle that sampled pc_addr_i.
REQ-024 The buffer SHALL be a 2-entry FIFO; instr_valid_o = not empty; the head pops on the edge where instr_valid_o and instr_ready_i are both 1.
REQ-025 Push and pop in the same cycle SHALL leave the count unchanged, with the remaining order preserved.
REQ-026 The issue rule in REQ-019 guarantees that a push never finds the buffer full; no overflow path exists.
REQ-027 flush_i=1 SHALL empty the buffer on the next edge and force pc_en_o=0 in that cycle.
REQ-028 Flush in REQ without grant SHALL go to IDLE, retracting the request; memory tolerates retraction before grant.
REQ-029 Flush in REQ with grant in the same cycle SHALL go to DISCARD.
REQ-030 Flush in WAIT SHALL go to DISCARD, or to IDLE if mem_rvalid_i=1 in that cycle; the response is dropped and not pushed.
REQ-031 DISCARD SHALL drop the response on mem_rvalid_i and go to IDLE; flush_i in DISCARD has no further effect.
REQ-032 After a flush, the first issued address SHALL be the branch target, which the PC presents one cycle after the flush.

Reset
REQ-033 reset_i=0 SHALL asynchronously force: state IDLE, buffer empty, mem_req_o=0, mem_addr_o=0, pc_en_o=0, instr_valid_o=0, instr_o=0, instr_addr_o=0, fetch_misaligned_o=0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding access; responses arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-035 With IFETCH_ALIGN_CHECK_EN defined: in IDLE, pc_addr_i[1:0] != 0 SHALL block issue and set fetch_misaligned_o; it stays set until flush_i.
REQ-036 Without IFETCH_ALIGN_CHECK_EN: pc_addr_i[1:0] are passed through unchecked and fetch_misaligned_o is tied to 0.

Verification
REQ-037 Reset, pc_addr_i=0x0, zero-wait memory, ready=1 -> instrs at 0x0, 0x4, 0x8 each appear 3 cycles apart; one pc_en_o pulse per grant.
REQ-038 ready=0, continuous fetch -> exactly 2 entries buffered (0x0, 0x4); no third mem_req_o until the first pop.
REQ-039 Flush during WAIT at addr 0x8, branch target 0x100 -> 0x8 response dropped; next instr_addr_o is 0x100; buffer empty after flush.
REQ-040 Flush in REQ with gnt in the same cycle -> DISCARD; the rvalid arriving 3 cycles later is dropped; pc_en_o stays 0 in the flush cycle.
REQ-041 With IFETCH_ALIGN_CHECK_EN, pc_addr_i=0x102 -> no mem_req_o, fetch_misaligned_o=1 until flush to 0x200, then normal fetch.
REQ-042 reset_i pulsed low in WAIT -> all outputs 0 immediately; a subsequent stray mem_rvalid_i produces no instr_valid_o.
